// File: rtl/log_unit_pipe_pkg.sv
// log_pkg: shared constants and types for the log_unit_pipe block.
//   LN2          ln(2) in UQ0.32
//   C*_W / C*_F  coefficient widths / fractional bits of the segment ROM
//   LATENCY      number of registered pipeline stages
//   stage_vld_t  per-stage valid vector
//   coef_t       one ROM entry {c0, c1, c2}
//   coef_calc    elaboration-time generator for a ROM entry
package log_pkg;

    localparam logic [31:0] LN2   = 32'hB17217F7;
    localparam int          LN2_F = 32;

    localparam int C0_W = 30;
    localparam int C1_W = 22;
    localparam int C2_W = 13;
    localparam int C0_F = 30;  // c0 = ln(1+a)          in [0, ln2)
    localparam int C1_F = 21;  // c1 = 1/(1+a)          in (0.5, 1]
    localparam int C2_F = 13;  // c2 = 1/(2*(1+a)^2)    in (0.125, 0.5]

    localparam int LATENCY = 6;

    typedef logic [LATENCY:1] stage_vld_t;

    typedef struct packed {
        logic [C0_W-1:0] c0;
        logic [C1_W-1:0] c1;
        logic [C2_W-1:0] c2;
    } coef_t;

    // Taylor coefficients of ln(1+a+t) around the segment start a = seg/2^seg_w:
    //   ln(1+a+t) ~= c0 + c1*t - c2*t^2
    // ln(1+a) uses the fast-converging form 2*atanh(a/(2+a)) in 60-bit fixed point.
    localparam int CF = 60;

    function automatic coef_t coef_calc(input int seg, input int seg_w);
        logic [127:0] one, den, z, z2, term, acc, r;
        coef_t        c;
        one  = 128'(1) << seg_w;
        den  = one + 128'(seg);
        z    = (128'(seg) << CF) / (den + one);
        z2   = (z * z) >> CF;
        term = z;
        acc  = '0;
        for (int n = 0; n < 24; n++) begin
            acc  = acc + term / 128'(2 * n + 1);
            term = (term * z2) >> CF;
        end
        r    = ((acc << 1) + (128'(1) << (CF - C0_F - 1))) >> (CF - C0_F);
        c.c0 = C0_W'(r);
        r    = ((one << C1_F) + (den >> 1)) / den;
        c.c1 = C1_W'(r);
        r    = (((one * one) << C2_F) + den * den) / (128'(2) * den * den);
        c.c2 = C2_W'(r);
        return c;
    endfunction

endpackage

// File: rtl/log_unit_pipe_if.sv
// log_unit_pipe_if: valid/ready stream bundle for the logarithm pipe.
//   in_valid/in_ready/u0       sample input (UQ0.U_W)
//   out_valid/out_ready/e/zero result output (e = -ln(u0), zero = u0 was 0)
//   master: producer/consumer side, slave: the log unit.
interface log_unit_pipe_if #(
    parameter int U_W = 48,
    parameter int E_W = 31
);
    logic           in_valid;
    logic           in_ready;
    logic [U_W-1:0] u0;
    logic           out_valid;
    logic           out_ready;
    logic [E_W-1:0] e;
    logic           zero;

    modport master (
        output in_valid, u0, out_ready,
        input  in_ready, out_valid, e, zero
    );

    modport slave (
        input  in_valid, u0, out_ready,
        output in_ready, out_valid, e, zero
    );
endinterface

// File: rtl/log_coef_rom.sv
// log_coef_rom: segment coefficient table for ln(1+x), x in [0,1).
//   addr  top SEG_W mantissa bits (segment index)
//   coef  {c0, c1, c2} for that segment, combinational read
// Contents are generated at elaboration from log_pkg::coef_calc, so the
// table follows SEG_W automatically.
module log_coef_rom
    import log_pkg::*;
#(
    parameter int SEG_W = 8
) (
    input  logic [SEG_W-1:0] addr,
    output coef_t            coef
);
    localparam int NSEG = 1 << SEG_W;

    coef_t tab [NSEG];

    for (genvar i = 0; i < NSEG; i++) begin : g_tab
        localparam coef_t ENTRY = coef_calc(i, SEG_W);
        assign tab[i] = ENTRY;
    end

    assign coef = tab[addr];
endmodule

// File: rtl/lzd_param.sv
// lzd_param: parametrised leading-zero detector.
//   din  W-bit word
//   p    number of leading zeros (W when din is 0)
//   nz   din is non-zero
module lzd_param #(
    parameter int W   = 48,
    parameter int P_W = $clog2(W + 1)
) (
    input  logic [W-1:0]   din,
    output logic [P_W-1:0] p,
    output logic           nz
);
    // Scan LSB to MSB so the highest set bit has the final say.
    always_comb begin
        p = P_W'(W);
        for (int i = 0; i < W; i++) begin
            if (din[i]) p = P_W'(W - 1 - i);
        end
    end

    assign nz = |din;
endmodule

// File: rtl/log_unit_pipe.sv
// log_unit_pipe: e = -ln(u0) for u0 in (0,1), 6-stage valid/ready pipeline.
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   io    log_unit_pipe_if.slave (in_valid/in_ready/u0, out_valid/out_ready/e/zero)
// u0 = 2^-k * (1+x) with k = leading zeros + 1, so -ln(u0) = k*ln2 - ln(1+x).
// ln(1+x) is a per-segment quadratic indexed by the top SEG_W bits of x.
// A stalled output (out_valid && !out_ready) freezes every stage.
// Build option: define LOG_ROUND_EN to round e to nearest (saturating)
// instead of truncating.
module log_unit_pipe
    import log_pkg::*;
#(
    parameter int U_W    = 48,
    parameter int SEG_W  = 8,
    parameter int E_W    = 31,
    parameter int FRAC_W = 25
) (
    input logic            clk,
    input logic            rst,
    log_unit_pipe_if.slave io
);
    localparam int K_W  = $clog2(U_W + 2);        // k ranges 1..U_W+1 (U_W+1 only for u0=0)
    localparam int XB_W = U_W - SEG_W;
    localparam int P1_W = C1_W + XB_W;
    localparam int P2_W = C2_W + XB_W;
    // Product fractional bits minus 32 -> shift to reach y's 32 frac bits.
    localparam int SH1  = C1_F + U_W - LN2_F;
    localparam int SH2  = C2_F + U_W + SEG_W - LN2_F;
    localparam int Y_W  = LN2_F + 2;               // signed, headroom above ln2
    localparam int D_W  = LN2_F + E_W - FRAC_W;    // k*ln2 with 32 frac bits

    // ---------------- handshake / valid pipeline ----------------
    stage_vld_t vld_pipe;
    logic       adv;

    assign adv          = !(vld_pipe[LATENCY] && !io.out_ready);
    assign io.in_ready  = adv;
    assign io.out_valid = vld_pipe[LATENCY];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     vld_pipe <= '0;
        else if (adv) vld_pipe <= {vld_pipe[LATENCY-1:1], io.in_valid};
    end

    // ---------------- S1: normalise ----------------
    logic [K_W-1:0] lz_p;
    logic           lz_nz;
    logic [K_W-1:0] k0;
    logic [U_W-1:0] x0;

    lzd_param #(.W(U_W), .P_W(K_W)) u_lzd (
        .din (io.u0),
        .p   (lz_p),
        .nz  (lz_nz)
    );

    assign k0 = lz_p + K_W'(1);
    assign x0 = io.u0 << k0;    // shifts the leading one out

    logic [K_W-1:0]   s1_k;
    logic [SEG_W-1:0] s1_xa;
    logic [XB_W-1:0]  s1_xb;
    logic             s1_nz;

    // ---------------- S2: ROM + xB^2 ----------------
    coef_t             rom_c;
    logic [2*XB_W-1:0] xb2;

    log_coef_rom #(.SEG_W(SEG_W)) u_rom (
        .addr (s1_xa),
        .coef (rom_c)
    );

    assign xb2 = (2*XB_W)'(s1_xb) * (2*XB_W)'(s1_xb);

    logic [K_W-1:0]  s2_k;
    logic            s2_nz;
    logic [XB_W-1:0] s2_xb;
    logic [XB_W-1:0] s2_xb2h;
    coef_t           s2_c;

    // ---------------- S3: products ----------------
    logic [K_W-1:0]  s3_k;
    logic            s3_nz;
    logic [C0_W-1:0] s3_c0;
    logic [P1_W-1:0] s3_p1;
    logic [P2_W-1:0] s3_p2;

    // ---------------- S4: k*ln2 ----------------
    logic [D_W-1:0]  s4_kln2;
    logic            s4_nz;
    logic [C0_W-1:0] s4_c0;
    logic [P1_W-1:0] s4_p1;
    logic [P2_W-1:0] s4_p2;

    // ---------------- S5: y = ln(1+x) ----------------
    logic [Y_W-1:0] y_nxt;

    assign y_nxt = (Y_W'(s4_c0) << (LN2_F - C0_F))
                 + Y_W'(s4_p1 >> SH1)
                 - Y_W'(s4_p2 >> SH2);

    logic [D_W-1:0] s5_kln2;
    logic [Y_W-1:0] s5_y;
    logic           s5_nz;

    always_ff @(posedge clk) begin
        if (adv) begin
            s1_k    <= k0;
            s1_xa   <= x0[U_W-1 -: SEG_W];
            s1_xb   <= x0[XB_W-1:0];
            s1_nz   <= lz_nz;

            s2_k    <= s1_k;
            s2_nz   <= s1_nz;
            s2_xb   <= s1_xb;
            s2_xb2h <= xb2[2*XB_W-1 -: XB_W];
            s2_c    <= rom_c;

            s3_k    <= s2_k;
            s3_nz   <= s2_nz;
            s3_c0   <= s2_c.c0;
            s3_p1   <= P1_W'(s2_c.c1) * P1_W'(s2_xb);
            s3_p2   <= P2_W'(s2_c.c2) * P2_W'(s2_xb2h);

            s4_kln2 <= D_W'(s3_k) * D_W'(LN2);
            s4_nz   <= s3_nz;
            s4_c0   <= s3_c0;
            s4_p1   <= s3_p1;
            s4_p2   <= s3_p2;

            s5_kln2 <= s4_kln2;
            s5_y    <= y_nxt;
            s5_nz   <= s4_nz;
        end
    end

    // ---------------- S6: d = k*ln2 - y, output format ----------------
    logic [D_W:0]   d_ext;
    logic [D_W-1:0] d;
    logic [E_W-1:0] e_nxt;

    // Clamp at zero so coefficient rounding near u0 -> 1 can never wrap.
    assign d_ext = {1'b0, s5_kln2} - {{(D_W + 1 - Y_W){s5_y[Y_W-1]}}, s5_y};
    assign d     = d_ext[D_W] ? '0 : d_ext[D_W-1:0];

`ifdef LOG_ROUND_EN
    logic [D_W:0] d_rnd;
    assign d_rnd = {1'b0, d} + ((D_W + 1)'(1) << (LN2_F - 1 - FRAC_W));
    assign e_nxt = d_rnd[D_W] ? '1 : d_rnd[D_W-1 -: E_W];
`else
    assign e_nxt = d[D_W-1 -: E_W];
`endif

    logic [E_W-1:0] e_q;
    logic           zero_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_q    <= '0;
            zero_q <= 1'b0;
        end else if (adv && vld_pipe[LATENCY-1]) begin
            e_q    <= s5_nz ? e_nxt : '0;
            zero_q <= !s5_nz;
        end
    end

    assign io.e    = e_q;
    assign io.zero = zero_q;
endmodule

// File: tb/tb_log_unit_pipe.sv
// Self-checking bench for log_unit_pipe: directed corner samples, reset
// behaviour and a randomized back-pressure run against a real-valued
// -ln(u0) model with an in-order expectation queue.
module tb_log_unit_pipe;
    localparam int U_W    = 48;
    localparam int E_W    = 31;
    localparam int FRAC_W = 25;
    localparam int LAT    = 6;
    localparam logic [U_W-1:0] HALF = U_W'(1) << (U_W - 1);
`ifdef LOG_ROUND_EN
    localparam longint E_HALF = 23258160;  // round(0xB17217F7 / 2^7)
`else
    localparam longint E_HALF = 23258159;  // floor(0xB17217F7 / 2^7)
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    log_unit_pipe_if #(.U_W(U_W), .E_W(E_W)) io ();

    log_unit_pipe #(.U_W(U_W), .SEG_W(8), .E_W(E_W), .FRAC_W(FRAC_W)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    typedef struct {
        logic [U_W-1:0] u;
        int             acc;
    } smp_t;

    smp_t           q[$];
    int             errors = 0;
    int             checks = 0;
    int             ncall  = 0;
    int             nout   = 0;
    bit             lat_chk;
    real            tol;
    bit             held   = 1'b0;
    logic [E_W-1:0] held_e;
    logic           held_z;

    function automatic real ref_e(input logic [U_W-1:0] u);
        real r;
        r = real'(u) / (2.0 ** U_W);
        return -$ln(r) * (2.0 ** FRAC_W);
    endfunction

    function automatic logic [U_W-1:0] rand_u();
        logic [63:0] r64;
        r64 = {$urandom(), $urandom()};
        if ($urandom_range(0, 15) == 0) return '0;
        return r64[U_W-1:0] >> $urandom_range(0, U_W - 1);
    endfunction

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_near(input string tag, input longint obs, input real rf, input real tl);
        checks++;
        assert ((real'(obs) >= rf - tl) && (real'(obs) <= rf + tl)) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%f tol=%f", tag, obs, rf, tl);
        end
    endtask

    // One clock: entered and left at a falling edge.
    task automatic cycle(input bit iv, input logic [U_W-1:0] u, input bit ordy, output bit accepted);
        smp_t s;
        if (held) begin
            chk_eq("hold_valid", 64'(io.out_valid), 64'd1);
            chk_eq("hold_e",     64'(io.e),         64'(held_e));
            chk_eq("hold_zero",  64'(io.zero),      64'(held_z));
        end
        io.in_valid  = iv;
        io.u0        = u;
        io.out_ready = ordy;
        #1;
        chk_eq("in_ready", 64'(io.in_ready), 64'(!(io.out_valid && !ordy)));
        held = 1'b0;
        if (io.out_valid && ordy) begin
            if (q.size() == 0) begin
                chk_eq("unexpected_out", 64'(io.out_valid), 64'd0);
            end else begin
                s = q.pop_front();
                if (s.u == '0) begin
                    chk_eq("zero_flag", 64'(io.zero), 64'd1);
                    chk_eq("zero_e",    64'(io.e),    64'd0);
                end else begin
                    chk_eq("nz_flag", 64'(io.zero), 64'd0);
                    chk_near("e", longint'(io.e), ref_e(s.u), tol);
                end
                if (s.u == HALF) chk_eq("half_exact", 64'(io.e), 64'(E_HALF));
                if (lat_chk) chk_eq("latency", 64'(ncall - s.acc), 64'(LAT));
            end
            nout++;
        end else if (io.out_valid) begin
            held   = 1'b1;
            held_e = io.e;
            held_z = io.zero;
        end
        accepted = iv && io.in_ready;
        if (accepted) q.push_back('{u, ncall});
        ncall++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1, a);
    endtask

    initial begin
        bit             acc;
        int             base;
        int             sent;
        bit             have;
        logic [U_W-1:0] u;

        io.in_valid  = 1'b0;
        io.u0        = '0;
        io.out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk_eq("rst_out_valid", 64'(io.out_valid), 64'd0);
        chk_eq("rst_e",         64'(io.e),         64'd0);
        chk_eq("rst_zero",      64'(io.zero),      64'd0);
        chk_eq("rst_in_ready",  64'(io.in_ready),  64'd1);
        rst = 1'b1;
        @(negedge clk);

        // Directed corners, back to back, latency checked
        lat_chk = 1'b1;
        tol     = 2.0;
        cycle(1'b1, HALF,     1'b1, acc);
        cycle(1'b1, '0,       1'b1, acc);
        cycle(1'b1, U_W'(1),  1'b1, acc);
        cycle(1'b1, '1,       1'b1, acc);
        cycle(1'b1, HALF >> 5, 1'b1, acc);
        idle(LAT + 2);
        chk_eq("directed_count", 64'(nout), 64'd5);

        // Reset with the pipeline full
        for (int i = 0; i < LAT; i++) cycle(1'b1, rand_u(), 1'b1, acc);
        chk_eq("pre_reset_valid", 64'(io.out_valid), 64'd1);
        rst = 1'b0;
        #1;
        chk_eq("reset_out_valid", 64'(io.out_valid), 64'd0);
        chk_eq("reset_e",         64'(io.e),         64'd0);
        chk_eq("reset_in_ready",  64'(io.in_ready),  64'd1);
        q.delete();
        held        = 1'b0;
        io.in_valid = 1'b0;
        @(negedge clk);
        rst  = 1'b1;
        base = nout;
        cycle(1'b1, HALF, 1'b1, acc);
        idle(LAT + 4);
        chk_eq("post_reset_count", 64'(nout - base), 64'd1);

        // Random samples with 50% back-pressure; producer holds until taken
        lat_chk = 1'b0;
        tol     = 4.0;
        base    = nout;
        sent    = 0;
        have    = 1'b0;
        u       = '0;
        for (int g = 0; g < 3000 && sent < 100; g++) begin
            if (!have) begin
                u    = rand_u();
                have = 1'b1;
            end
            cycle(1'b1, u, 1'($urandom_range(0, 1)), acc);
            if (acc) begin
                have = 1'b0;
                sent++;
            end
        end
        for (int g = 0; g < 400 && (nout - base) < 100; g++)
            cycle(1'b0, '0, 1'($urandom_range(0, 1)), acc);
        chk_eq("rand_sent",  64'(sent),        64'd100);
        chk_eq("rand_count", 64'(nout - base), 64'd100);
        chk_eq("rand_drain", 64'(q.size()),    64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
